instr_byte_fetch: RTL and testbench
===================================

# instr_byte_fetch

Fetch stage directly upstream of the decode/control stage. Accepts instruction bytes from the 8-bit chip input bus, assembles them little-endian into 32-bit RV32I words, and buffers complete words in a small FIFO. It presents the head word and its decoded fields (opcode, func3, func7, register indices, I-immediate) to decode under a valid/ready handshake. A flush input discards all partial and buffered state on a taken branch.

## Interface
- OP_WIDTH, 7, opcode and func7 width.
- FIFO_DEPTH, 2, buffered complete instructions; power of two, ≥2.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- byte_in  in  8  instruction byte; byte 0 is instr[7:0].
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  byte accepted at this edge if byte_valid is also high.
- flush  in  1  discard partial word and all FIFO contents.
- instr_ready  in  1  decode consumes the head word this edge.
- instr_valid  out  1  FIFO non-empty.
- instr  out  32  head word; forced to 0 when instr_valid=0.
- opcode  out  OP_WIDTH  instr[6:0].
- rd  out  5  instr[11:7].
- func3  out  3  instr[14:12].
- rs1  out  5  instr[19:15].
- rs2  out  5  instr[24:20].
- func7  out  OP_WIDTH  instr[31:25].
- imm_i  out  12  instr[31:20], raw, unextended.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- Assembler: byte counter cnt[1:0] plus 24-bit holding register. An accept (byte_valid && byte_ready) with cnt<3 stores the byte in lane cnt and increments cnt.
- An accept with cnt==3 pushes {byte_in, hold[23:0]} into the FIFO. cnt wraps to 0.
- byte_ready = !(cnt==3 && fifo_level==FIFO_DEPTH). It depends on registered state only, with no combinational path from instr_ready. Bytes 0–2 are accepted even when the FIFO is full.
- Pop: instr_valid && instr_ready at the edge advances the read pointer. instr_ready with the FIFO empty is ignored.
- Simultaneous push and pop: level unchanged, ordering preserved. Push-when-full cannot occur because byte_ready is low.
- Field outputs are combinational slices of instr. An empty FIFO yields all zeros; opcode 0 makes the control stage issue a bubble (no write-back).
- Flush has priority over every other event in its cycle. On the edge where flush=1: cnt←0, FIFO level←0, pointers←0. The byte and the pop offered that cycle are both dropped.
- Reset (rst=1 at edge) has the same effect as flush. Reset values: instr_valid=0, byte_ready=1, instr and all fields 0, fifo_level=0, hold register 0.
- Reset or flush during partial assembly discards the partial bytes. The next accepted byte is treated as byte 0.

## Timing
- Latency: 4th byte accepted at edge N; instr_valid=1 and fields valid in cycle N+1.
- Throughput: one byte per cycle sustained, i.e. one instruction per 4 cycles, with no bubble at the word wrap.
- Pop at edge N: the next head appears in cycle N+1, or instr_valid=0 if the FIFO is now empty.
- byte_ready falls in the cycle after the FIFO becomes full while cnt==3. It rises the cycle after a pop or flush.
- No output has a combinational path from any input except through registered state. The exception is instr, which is registered storage muxed by valid.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants OPC_RTYPE=7'b0110011, OPC_ITYPE=7'b0010011, OPC_BRANCH=7'b1100011;
  - field bit positions;
  - INSTR_W=32.
  - The control unit and this block both use it.
- Sub-module `sync_fifo` (WIDTH, DEPTH): synchronous FIFO with push, pop, clear, level and head outputs. The top level holds the assembler, flush/reset priority logic and field slicing.

## Test plan
- Reset, then bytes B3,81,20,00 on consecutive cycles, instr_ready=1:
  - cycle after the 4th byte: instr=0x002081B3, opcode=0x33, rd=3, rs1=1, rs2=2, func3=0, func7=0;
  - popped next edge; instr_valid returns 0.
- Bytes 93,02,F0,FF: instr=0xFFF00293, opcode=0x13, rd=5, rs1=0, imm_i=0xFFF.
- instr_ready=0, stream 12 bytes:
  - after 8 bytes, fifo_level=2;
  - bytes 9–11 accepted; byte_ready=0 with cnt==3;
  - one pop → byte_ready=1 next cycle; 12th byte completes the third word, in order.
- Two bytes of a word, then flush with byte_valid=1:
  - fifo_level=0 and instr_valid=0 next cycle;
  - the next 4 bytes form a clean word with no stale lanes.
- FIFO at level 1: push the 4th byte and pop on the same edge → level stays 1 and the head becomes the new word.
- rst asserted mid-word with FIFO full: next cycle all outputs 0, byte_ready=1, fifo_level=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared RV32I definitions used by the fetch stage and the control unit.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned F3_LSB  = 12;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned IMM_LSB = 20;
  localparam int unsigned F7_LSB  = 25;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with clear, occupancy level and combinational head output.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [LVL_W-1:0] r_level;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_level == LVL_W'(DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !w_empty;

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset: consumers qualify the head with the level.
  always_ff @(posedge i_clk) begin
    if (!i_clear && w_do_push) r_mem[r_wptr] <= i_data;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_level = r_level;

endmodule

// File: rtl/instr_byte_fetch.sv
// Byte-serial instruction fetch: assembles little-endian RV32I words, buffers them,
// and presents the head word with its decoded fields to decode.
module instr_byte_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned OP_WIDTH   = 7,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [7:0]                    i_byte_in,
  input  logic                          i_byte_valid,
  output logic                          o_byte_ready,
  input  logic                          i_flush,
  input  logic                          i_instr_ready,
  output logic                          o_instr_valid,
  output logic [INSTR_W-1:0]            o_instr,
  output logic [OP_WIDTH-1:0]           o_opcode,
  output logic [4:0]                    o_rd,
  output logic [2:0]                    o_func3,
  output logic [4:0]                    o_rs1,
  output logic [4:0]                    o_rs2,
  output logic [OP_WIDTH-1:0]           o_func7,
  output logic [11:0]                   o_imm_i,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]         r_cnt;
  logic [23:0]        r_hold;

  logic               w_clear;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic [INSTR_W-1:0] w_head;
  logic [INSTR_W-1:0] w_instr;
  logic [LVL_W-1:0]   w_level;

  assign w_clear       = i_rst || i_flush;
  assign o_instr_valid = (w_level != '0);
  // Only stall when the byte on offer would complete a word with nowhere to go.
  assign o_byte_ready  = !((r_cnt == 2'd3) && (w_level == LVL_W'(FIFO_DEPTH)));
  assign w_accept      = i_byte_valid && o_byte_ready;
  assign w_push        = !w_clear && w_accept && (r_cnt == 2'd3);
  assign w_pop         = !w_clear && i_instr_ready && o_instr_valid;

  always_ff @(posedge i_clk) begin
    if (w_clear) begin
      r_cnt  <= 2'd0;
      r_hold <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + 2'd1;
      unique case (r_cnt)
        2'd0:    r_hold[7:0]   <= i_byte_in;
        2'd1:    r_hold[15:8]  <= i_byte_in;
        2'd2:    r_hold[23:16] <= i_byte_in;
        default: r_hold        <= r_hold;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_clear (w_clear),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({i_byte_in, r_hold}),
    .o_head  (w_head),
    .o_level (w_level)
  );

  assign w_instr      = o_instr_valid ? w_head : '0;
  assign o_instr      = w_instr;
  assign o_fifo_level = w_level;

  assign o_opcode = w_instr[OPC_LSB +: OP_WIDTH];
  assign o_rd     = w_instr[RD_LSB +: 5];
  assign o_func3  = w_instr[F3_LSB +: 3];
  assign o_rs1    = w_instr[RS1_LSB +: 5];
  assign o_rs2    = w_instr[RS2_LSB +: 5];
  assign o_func7  = w_instr[F7_LSB +: OP_WIDTH];
  assign o_imm_i  = w_instr[IMM_LSB +: 12];

endmodule

// File: tb/tb_instr_byte_fetch.sv
// Directed bench for instr_byte_fetch with a byte/word queue reference model.
module tb_instr_byte_fetch;
  import cpu_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic        clk;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        flush;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  func3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  func7;
  logic [11:0] imm_i;
  logic [1:0]  fifo_level;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  logic [31:0] m_q[$];
  logic [7:0]  m_part[$];

  instr_byte_fetch #(
    .OP_WIDTH   (7),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_byte_in     (byte_in),
    .i_byte_valid  (byte_valid),
    .o_byte_ready  (byte_ready),
    .i_flush       (flush),
    .i_instr_ready (instr_ready),
    .o_instr_valid (instr_valid),
    .o_instr       (instr),
    .o_opcode      (opcode),
    .o_rd          (rd),
    .o_func3       (func3),
    .o_rs1         (rs1),
    .o_rs2         (rs2),
    .o_func7       (func7),
    .o_imm_i       (imm_i),
    .o_fifo_level  (fifo_level)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: partial bytes and complete words as plain queues.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] w;
      logic        exp_rdy;
      w = (m_q.size() != 0) ? m_q[0] : 32'h0;
      exp_rdy = !(m_part.size() == 3 && m_q.size() == DEPTH);
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_q.size() != 0});
      chk("instr", instr, w);
      chk("opcode", {25'b0, opcode}, {25'b0, w[6:0]});
      chk("rd", {27'b0, rd}, {27'b0, w[11:7]});
      chk("func3", {29'b0, func3}, {29'b0, w[14:12]});
      chk("rs1", {27'b0, rs1}, {27'b0, w[19:15]});
      chk("rs2", {27'b0, rs2}, {27'b0, w[24:20]});
      chk("func7", {25'b0, func7}, {25'b0, w[31:25]});
      chk("imm_i", {20'b0, imm_i}, {20'b0, w[31:20]});
      chk("byte_ready", {31'b0, byte_ready}, {31'b0, exp_rdy});
      chk("fifo_level", {30'b0, fifo_level}, m_q.size());
    end
  end

  task automatic cyc(input logic v, input logic [7:0] b, input logic rdy,
                     input logic fl = 1'b0, input logic rs = 1'b0);
    logic exp_rdy;
    byte_valid  = v;
    byte_in     = b;
    instr_ready = rdy;
    flush       = fl;
    rst         = rs;
    @(posedge clk);
    exp_rdy = !(m_part.size() == 3 && m_q.size() == DEPTH);
    if (rs || fl) begin
      m_q.delete();
      m_part.delete();
    end else begin
      if (rdy && m_q.size() != 0) void'(m_q.pop_front());
      if (v && exp_rdy) begin
        m_part.push_back(b);
        if (m_part.size() == 4) begin
          m_q.push_back({m_part[3], m_part[2], m_part[1], m_part[0]});
          m_part.delete();
        end
      end
    end
    #1;
    byte_valid = 0;
    instr_ready = 0;
    flush = 0;
    rst = 0;
  endtask

  task automatic feed4(input logic [31:0] w, input logic rdy);
    for (int i = 0; i < 4; i++) cyc(1'b1, w[8*i +: 8], rdy);
  endtask

  initial begin
    byte_valid = 0; byte_in = 0; instr_ready = 0; flush = 0; rst = 1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk_en = 1;
    chk("reset instr", instr, 32'h0);
    chk("reset byte_ready", {31'b0, byte_ready}, 32'd1);
    chk("reset level", {30'b0, fifo_level}, 32'd0);

    // R-type add x3,x1,x2
    feed4(32'h002081B3, 1'b1);
    chk("rtype instr", instr, 32'h002081B3);
    chk("rtype opcode", {25'b0, opcode}, {25'b0, OPC_RTYPE});
    chk("rtype rd", {27'b0, rd}, 32'd3);
    chk("rtype rs1", {27'b0, rs1}, 32'd1);
    chk("rtype rs2", {27'b0, rs2}, 32'd2);
    cyc(1'b0, 8'h00, 1'b1);
    chk("rtype popped", {31'b0, instr_valid}, 32'd0);

    // I-type addi x5,x0,-1
    feed4(32'hFFF00293, 1'b0);
    chk("itype instr", instr, 32'hFFF00293);
    chk("itype opcode", {25'b0, opcode}, 32'h13);
    chk("itype rd", {27'b0, rd}, 32'd5);
    chk("itype imm", {20'b0, imm_i}, 32'hFFF);
    cyc(1'b0, 8'h00, 1'b1);

    // Fill the FIFO and stall on the 12th byte
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
    chk("full level", {30'b0, fifo_level}, 32'd2);
    for (int i = 8; i < 11; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
    chk("stall ready", {31'b0, byte_ready}, 32'd0);
    cyc(1'b1, 8'h1B, 1'b0);
    chk("stall hold level", {30'b0, fifo_level}, 32'd2);
    cyc(1'b0, 8'h00, 1'b1);
    chk("ready after pop", {31'b0, byte_ready}, 32'd1);
    chk("second word", instr, 32'h17161514);
    cyc(1'b1, 8'h1B, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("third word", instr, 32'h1B1A1918);
    cyc(1'b0, 8'h00, 1'b1);

    // Flush mid-word drops the partial bytes and the offered byte
    cyc(1'b1, 8'hAA, 1'b0);
    cyc(1'b1, 8'hBB, 1'b0);
    cyc(1'b1, 8'hCC, 1'b1, 1'b1);
    chk("flush level", {30'b0, fifo_level}, 32'd0);
    chk("flush valid", {31'b0, instr_valid}, 32'd0);
    feed4(32'h04030201, 1'b0);
    chk("post flush word", instr, 32'h04030201);

    // Push and pop on the same edge at level 1
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h11 * (i + 1)), 1'b0);
    cyc(1'b1, 8'h44, 1'b1);
    chk("pushpop level", {30'b0, fifo_level}, 32'd1);
    chk("pushpop head", instr, 32'h44332211);

    // Reset mid-word with the FIFO full
    feed4(32'h88776655, 1'b0);
    cyc(1'b1, 8'h99, 1'b0);
    cyc(1'b1, 8'hAA, 1'b0);
    cyc(1'b1, 8'hBB, 1'b1, 1'b0, 1'b1);
    chk("rst instr", instr, 32'h0);
    chk("rst opcode", {25'b0, opcode}, 32'h0);
    chk("rst ready", {31'b0, byte_ready}, 32'd1);
    chk("rst level", {30'b0, fifo_level}, 32'd0);
    feed4(32'hC4C3C2C1, 1'b0);
    chk("post rst word", instr, 32'hC4C3C2C1);
    cyc(1'b0, 8'h00, 1'b1);

    #10;
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
